// File: rtl/risc_pkg.sv
// Shared encodings, widths and the EX/WB stage-register layout for the RISC pipeline.
package risc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] MD_F   = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_SLT = 2'b10;

  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_BRA  = 2'b10;
  localparam logic [1:0] BS_JMR  = 2'b11;

  typedef enum logic {StIdle, StFlush} flush_state_e;

  typedef struct packed {
    logic              rw;
    logic [REG_AW-1:0] da;
    logic [1:0]        md;
    logic [1:0]        bs;
    logic              ps;
    logic              mw;
    logic [DATA_W-1:0] f;
    logic              n_xor_v;
    logic              z;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] bra;
    logic [DATA_W-1:0] raa;
  } ex_wb_t;

endpackage

// File: rtl/risc_data_mem.sv
// Word-addressed data memory: synchronous write, combinational read, storage not reset.
module risc_data_mem #(
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(2**MEM_AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/risc_wb_stage.sv
// Write-back stage: EX/WB register, data memory, RF write port, branch resolution and the
// flush sequencer that bubbles younger instructions after a taken branch.
module risc_wb_stage
  import risc_pkg::*;
#(
  parameter int unsigned MEM_AW       = 8,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_WB_RW,
  input  logic [4:0]  EX_WB_DA,
  input  logic [1:0]  EX_WB_MD,
  input  logic [1:0]  EX_WB_BS,
  input  logic        EX_WB_PS,
  input  logic        EX_WB_MW,
  input  logic [31:0] EX_WB_F,
  input  logic        EX_WB_N_XOR_V,
  input  logic        EX_WB_Z,
  input  logic [31:0] EX_WB_Data_Mem_Addr,
  input  logic [31:0] Ex_WB_Data_Mem_Data_In,
  input  logic [31:0] EX_WB_BrA,
  input  logic [31:0] EX_WB_RAA,
  output logic        WB_RF_We,
  output logic [4:0]  WB_RF_Addr,
  output logic [31:0] WB_RF_Data,
  output logic        WB_Branch_Taken,
  output logic [31:0] WB_Target,
  output logic        WB_Flush
);

  ex_wb_t       stage_d, stage_q;
  flush_state_e state_d, state_q;
  logic [2:0]   cnt_d, cnt_q;
  logic [31:0]  mem_rdata;
  logic         taken;
  logic [31:0]  target;
  logic         unused_addr_hi;

  // Upper address bits are deliberately ignored so addresses wrap.
  assign unused_addr_hi = ^stage_q.addr[DATA_W-1:MEM_AW];

  always_comb begin
    stage_d.rw      = EX_WB_RW;
    stage_d.da      = EX_WB_DA;
    stage_d.md      = EX_WB_MD;
    stage_d.bs      = EX_WB_BS;
    stage_d.ps      = EX_WB_PS;
    stage_d.mw      = EX_WB_MW;
    stage_d.f       = EX_WB_F;
    stage_d.n_xor_v = EX_WB_N_XOR_V;
    stage_d.z       = EX_WB_Z;
    stage_d.addr    = EX_WB_Data_Mem_Addr;
    stage_d.wdata   = Ex_WB_Data_Mem_Data_In;
    stage_d.bra     = EX_WB_BrA;
    stage_d.raa     = EX_WB_RAA;
    if (WB_Flush) begin
      stage_d.rw = 1'b0;
      stage_d.mw = 1'b0;
      stage_d.bs = BS_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      stage_q <= stage_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  risc_data_mem #(
    .MEM_AW(MEM_AW),
    .DATA_W(DATA_W)
  ) u_data_mem (
    .clk_i  (clk),
    .we_i   (stage_q.mw),
    .addr_i (stage_q.addr[MEM_AW-1:0]),
    .wdata_i(stage_q.wdata),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (stage_q.bs)
      BS_COND: begin
        if (stage_q.z == stage_q.ps) begin
          taken  = 1'b1;
          target = stage_q.bra;
        end
      end
      BS_BRA: begin
        taken  = 1'b1;
        target = stage_q.bra;
      end
      BS_JMR: begin
        taken  = 1'b1;
        target = stage_q.raa;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (stage_q.md)
      MD_MEM:  WB_RF_Data = mem_rdata;
      MD_SLT:  WB_RF_Data = {31'b0, stage_q.n_xor_v};
      default: WB_RF_Data = stage_q.f;
    endcase
  end

  // The branch cycle itself is the first flush cycle, so FLUSH covers the remaining ones.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (taken && (FLUSH_CYCLES > 1)) begin
          state_d = StFlush;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
        end
      end
      StFlush: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign WB_RF_We        = stage_q.rw && (stage_q.da != 5'd0);
  assign WB_RF_Addr      = stage_q.da;
  assign WB_Branch_Taken = taken;
  assign WB_Target       = target;
  assign WB_Flush        = taken || (state_q == StFlush);

endmodule
